button_debounce: RTL
====================

Name: button_debounce

Overview:
- Upstream conditioning stage for the board push-button (KEY) that drives the LED blinker's reset/control input.
- Synchronises the raw asynchronous button into CLOCK_50 and rejects bounce with a stable-time filter.
- Emits a clean level plus one-cycle press/release pulses and a wrapping press counter, so the blinker and later stages never see contact bounce.

Parameters:
- DEBOUNCE_CYCLES, 5000, number of consecutive stable cycles required to accept a level change; legal range is 1 or more.
- LONG_CYCLES, 50000000, hold time in cycles before long_pulse fires; used only with LONG_PRESS_EN.
- BTN_ACTIVE, 0, raw level meaning "pressed"; 0 suits the active-low board KEYs.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz; all flops use the rising edge.
- reset  input  1  asynchronous, active-low reset; asserted while 0, released synchronously by design.
- btn_raw  input  1  raw button pin, asynchronous to CLOCK_50.
- pressed  output  1  debounced level; 1 means the button is held.
- press_pulse  output  1  one-cycle pulse when a press is accepted.
- release_pulse  output  1  one-cycle pulse when a release is accepted.
- press_count  output  8  number of accepted presses; wraps modulo 256.
- long_pulse  output  1  one-cycle pulse on a long hold; tied to 0 without LONG_PRESS_EN.

Behaviour:
Reset (reset=0, asynchronous):
- State is RELEASED and cnt=0.
- Both synchroniser flops load the released level, ~BTN_ACTIVE.
- All outputs are 0, including press_count.

Synchronisation and normalisation:
- Two-flop synchroniser on btn_raw.
- The normalised request is p_s = (sync_out == BTN_ACTIVE).
- No logic reads btn_raw directly.

Counter:
- cnt width is $clog2(DEBOUNCE_CYCLES)+1, so it never overflows.
- cnt is cleared on every entry to a WAIT state.
- While in a WAIT state with the input stable: if cnt == DEBOUNCE_CYCLES-1, the FSM transitions; otherwise cnt increments.

FSM, registered, evaluated each rising edge:
- RELEASED: if p_s=1, go to PRESS_WAIT with cnt=0.
- PRESS_WAIT, p_s=0: glitch; go back to RELEASED with no outputs.
- PRESS_WAIT, p_s=1 and count reached: go to PRESSED. Set pressed=1, press_pulse=1 for one cycle, and press_count+1.
- PRESSED: if p_s=0, go to RELEASE_WAIT with cnt=0.
- RELEASE_WAIT, p_s=1: bounce; go back to PRESSED. pressed stays 1 and no pulse fires.
- RELEASE_WAIT, p_s=0 and count reached: go to RELEASED. Set pressed=0 and release_pulse=1 for one cycle.

Latency:
- btn_raw changes before edge k and then stays stable.
- The synchroniser output changes at edge k+1.
- The FSM enters WAIT at edge k+2.
- pressed/pulse update at edge k+2+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles after the first sampling edge.

Boundary rules:
- Pulses never overlap, and never repeat without an intervening accepted opposite edge.
- press_count goes 255 -> 0 on the next accepted press; no flag is raised.
- DEBOUNCE_CYCLES=1 gives an acceptance on the first WAIT cycle.
- Reset asserted mid-WAIT or mid-PRESSED returns immediately to reset values. No release_pulse is generated for the aborted press.
- Any bounce shorter than DEBOUNCE_CYCLES is fully invisible at the outputs.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_LONG_PRESS_EN.
- Defined, hold counter:
  - A hold counter of width $clog2(LONG_CYCLES)+1 increments in PRESSED and RELEASE_WAIT.
  - It is cleared on entering RELEASED and at reset.
- Defined, long_pulse:
  - When the hold counter reaches LONG_CYCLES-1, long_pulse=1 for one cycle. This equals LONG_CYCLES cycles after press acceptance.
  - The counter then saturates, so there is only one long_pulse per press.
  - A short bounce into RELEASE_WAIT does not restart the hold count.
- Undefined:
  - No hold counter exists.
  - long_pulse is a constant 0.
  - The port list is unchanged.

Test Plan (DEBOUNCE_CYCLES=8, LONG_CYCLES=40, BTN_ACTIVE=0):
1. Reset, then btn_raw=1 for 100 cycles -> pressed=0, no pulses, press_count=0.
2. btn_raw=0 held from edge k -> pressed=1 and press_pulse=1 exactly at edge k+10; press_count=1; press_pulse=0 at edge k+11.
3. Press bounce: toggle btn_raw every 3 cycles for 30 cycles, then hold 0 -> exactly one press_pulse, 10 cycles after the last toggle; no release_pulse.
4. While pressed, release glitch of btn_raw=1 for 5 cycles -> pressed stays 1, no release_pulse. Then release for 20 cycles -> release_pulse once, 10 cycles after the release edge.
5. Issue 257 clean presses -> press_count reads 1 after the 257th. The 256th press shows the 255->0 wrap.
6. Hold press, then pulse reset=0 for 1 cycle -> all outputs 0 immediately, no release_pulse afterward.
   - With BUTTON_DEBOUNCE_LONG_PRESS_EN, hold 100 cycles -> a single long_pulse 40 cycles after press_pulse.

Source files
------------

// File: rtl/button_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce_if
//  Purpose  : Signal bundle between the push-button conditioning stage and
//             its consumer (LED blinker control).
//  Signals  : btn_raw       raw button pin, asynchronous to CLOCK_50
//             pressed       debounced level, 1 = held
//             press_pulse   one-cycle pulse on an accepted press
//             release_pulse one-cycle pulse on an accepted release
//             press_count   accepted presses, wraps modulo 256
//             long_pulse    one-cycle pulse on a long hold
//  Modports : master - drives the button pin, consumes the conditioned outputs
//             slave  - the debouncer itself
//  Revision : 1.0 - initial release
// ============================================================================
interface button_debounce_if;
    logic       btn_raw;
    logic       pressed;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_count;
    logic       long_pulse;

    modport master (
        output btn_raw,
        input  pressed,
        input  press_pulse,
        input  release_pulse,
        input  press_count,
        input  long_pulse
    );

    modport slave (
        input  btn_raw,
        output pressed,
        output press_pulse,
        output release_pulse,
        output press_count,
        output long_pulse
    );
endinterface
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce
//  Purpose  : Synchronises the raw board push-button into CLOCK_50, rejects
//             contact bounce with a stable-time filter, and produces a clean
//             level, one-cycle press/release pulses and a wrapping press count.
//  Ports    : CLOCK_50  system clock (rising edge)
//             reset     asynchronous active-low reset
//             bus       button_debounce_if.slave (btn_raw in; pressed,
//                       press_pulse, release_pulse, press_count, long_pulse out)
//  Params   : DEBOUNCE_CYCLES  stable cycles needed to accept a change (>= 1)
//             LONG_CYCLES      hold time before long_pulse (>= 1)
//             BTN_ACTIVE       raw pin level that means "pressed"
//  Options  : BUTTON_DEBOUNCE_LONG_PRESS_EN - when defined, adds the hold
//             counter and long_pulse; otherwise long_pulse is constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit BTN_ACTIVE      = 1'b0
) (
    input  wire logic         CLOCK_50,
    input  wire logic         reset,
    button_debounce_if.slave  bus
);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
        $error("button_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
    end

    // One extra bit of headroom so the stable counter can never wrap.
    localparam int            c_CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; resets to the released level so a button
    // held through reset is seen as a fresh press afterwards.
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_p_s;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_sync1 <= ~BTN_ACTIVE;
            r_sync2 <= ~BTN_ACTIVE;
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_p_s = (r_sync2 == BTN_ACTIVE);

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            r_pressed;
    logic            w_pressed_nxt;
    logic            r_press_pulse;
    logic            w_press_pulse_nxt;
    logic            r_release_pulse;
    logic            w_release_pulse_nxt;
    logic [7:0]      r_press_count;
    logic [7:0]      w_press_count_nxt;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state         <= S_RELEASED;
            r_cnt           <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_press_count   <= 8'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_pressed       <= w_pressed_nxt;
            r_press_pulse   <= w_press_pulse_nxt;
            r_release_pulse <= w_release_pulse_nxt;
            r_press_count   <= w_press_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_pressed_nxt       = r_pressed;
        w_press_pulse_nxt   = 1'b0;
        w_release_pulse_nxt = 1'b0;
        w_press_count_nxt   = r_press_count;

        case (r_state)
            S_RELEASED: begin
                if (w_p_s) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end

            S_PRESS_WAIT: begin
                if (!w_p_s) begin
                    // Too short to be a press: drop it silently.
                    w_state_nxt = S_RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt       = S_PRESSED;
                    w_cnt_nxt         = '0;
                    w_pressed_nxt     = 1'b1;
                    w_press_pulse_nxt = 1'b1;
                    w_press_count_nxt = r_press_count + 8'd1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            S_PRESSED: begin
                if (!w_p_s) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end

            S_RELEASE_WAIT: begin
                if (w_p_s) begin
                    // Release bounce: still held, level never dropped.
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt         = S_RELEASED;
                    w_cnt_nxt           = '0;
                    w_pressed_nxt       = 1'b0;
                    w_release_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = S_RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.pressed       = r_pressed;
    assign bus.press_pulse   = r_press_pulse;
    assign bus.release_pulse = r_release_pulse;
    assign bus.press_count   = r_press_count;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    // ------------------------------------------------------------------
    // Hold timer: runs while the button is (possibly bouncing) held, so a
    // short release bounce does not restart it. After firing it parks at
    // LONG_CYCLES, giving one long_pulse per press.
    // ------------------------------------------------------------------
    localparam int              c_HW        = $clog2(LONG_CYCLES) + 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(LONG_CYCLES - 1);
    localparam logic [c_HW-1:0] c_HOLD_SAT  = c_HW'(LONG_CYCLES);
    localparam logic [c_HW-1:0] c_HOLD_ONE  = c_HW'(1);

    logic [c_HW-1:0] r_hold;
    logic [c_HW-1:0] w_hold_nxt;
    logic            r_long_pulse;
    logic            w_long_pulse_nxt;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_hold       <= '0;
            r_long_pulse <= 1'b0;
        end else begin
            r_hold       <= w_hold_nxt;
            r_long_pulse <= w_long_pulse_nxt;
        end
    end

    always_comb begin
        w_hold_nxt       = r_hold;
        w_long_pulse_nxt = 1'b0;
        if (w_state_nxt == S_RELEASED) begin
            // Also suppresses a long pulse on the same edge as a release,
            // keeping pulses mutually exclusive.
            w_hold_nxt = '0;
        end else if (r_state == S_PRESSED || r_state == S_RELEASE_WAIT) begin
            if (r_hold < c_HOLD_LAST) begin
                w_hold_nxt = r_hold + c_HOLD_ONE;
            end else if (r_hold == c_HOLD_LAST) begin
                w_hold_nxt       = c_HOLD_SAT;
                w_long_pulse_nxt = 1'b1;
            end
        end
    end

    assign bus.long_pulse = r_long_pulse;
`else
    assign bus.long_pulse = 1'b0;
`endif

endmodule
`default_nettype wire
